mod_inverse_engine: RTL and testbench

Parametrised binary extended-Euclid modular inverse engine: computes R = a⁻¹ mod p for odd modulus p and reports non-invertible operands instead of hanging. Successor to the fixed Init/Work1/Work2/Output inverter in the Paillier datapath. Adds:
- valid/ready handshakes on both sides, with output backpressure
- operand range checks and gcd≠1 error detection
- a request tag passed through to the result
- a saturating iteration counter for latency profiling

Sits between key-generation/decryption control and the Montgomery exponentiation units.

---
 rtl/mod_inv_pkg.sv | 24 ++
 rtl/mod_inv_halve.sv | 16 +
 rtl/mod_inverse_engine.sv | 149 ++++++++++++++
 tb/tb_mod_inverse_engine.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mod_inv_pkg.sv
// rtl/mod_inv_pkg.sv - shared types and sizing helpers for the modular inverse engine
package mod_inv_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CHECK = 3'd1,
      HALVE = 3'd2,
      SUB   = 3'd3,
      DONE  = 3'd4
   } inv_state_t;

   localparam int GUARD_BITS = 1;

   // Width of subtract results: one extra bit so the top bit reads as the borrow.
   function automatic int guard_w(input int data_width);
      return data_width + GUARD_BITS;
   endfunction

   // All-ones saturation point of the iteration counter.
   function automatic int cnt_sat_bits(input int cnt_width);
      return cnt_width;
   endfunction

endpackage

// File: rtl/mod_inv_halve.sv
// rtl/mod_inv_halve.sv - modular halving: v even ? v/2 : (v+p)/2, p odd
module mod_inv_halve #(
   parameter int DATA_WIDTH = 4096
) (
   input  logic [DATA_WIDTH-1:0] v,
   input  logic [DATA_WIDTH-1:0] p,
   output logic [DATA_WIDTH-1:0] half
);

   logic [DATA_WIDTH:0] sum;

   // (v+p)/2 is formed at DATA_WIDTH+1 bits; the result always fits back in DATA_WIDTH.
   assign sum  = {1'b0, v} + (v[0] ? {1'b0, p} : {(DATA_WIDTH+1){1'b0}});
   assign half = sum[DATA_WIDTH:1] | {{(DATA_WIDTH-1){1'b0}}, sum[0] & 1'b0};

endmodule

// File: rtl/mod_inverse_engine.sv
// rtl/mod_inverse_engine.sv - binary extended-Euclid a^-1 mod p with handshakes and error reporting
module mod_inverse_engine
   import mod_inv_pkg::*;
#(
   parameter int DATA_WIDTH = 4096,
   parameter int TAG_WIDTH  = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_a,
   input  logic [DATA_WIDTH-1:0] in_p,
   input  logic [TAG_WIDTH-1:0]  in_tag,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_r,
   output logic                  out_err,
   output logic [TAG_WIDTH-1:0]  out_tag,
   output logic [CNT_WIDTH-1:0]  out_iter,
   output logic                  busy
);

   localparam int GW = guard_w(DATA_WIDTH);
   localparam logic [DATA_WIDTH-1:0] ONE_D   = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_WIDTH-1:0]  ONE_C   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_WIDTH-1:0]  CNT_MAX = {cnt_sat_bits(CNT_WIDTH){1'b1}};

   inv_state_t            state;
   logic [DATA_WIDTH-1:0] u, v, x, y, p_q;
   logic [TAG_WIDTH-1:0]  tag_q;
   logic [CNT_WIDTH-1:0]  iter;
   logic [DATA_WIDTH-1:0] x_half, y_half;
   logic [GW-1:0]         u_sub_v, v_sub_u, x_sub_y, y_sub_x;
   logic [CNT_WIDTH-1:0]  iter_next;
   logic                  pre_bad;

   mod_inv_halve #(.DATA_WIDTH(DATA_WIDTH)) u_halve_x (.v(x), .p(p_q), .half(x_half));
   mod_inv_halve #(.DATA_WIDTH(DATA_WIDTH)) u_halve_y (.v(y), .p(p_q), .half(y_half));

   // Top bit of each guarded difference is the borrow, i.e. minuend < subtrahend.
   assign u_sub_v   = {1'b0, u} - {1'b0, v};
   assign v_sub_u   = {1'b0, v} - {1'b0, u};
   assign x_sub_y   = {1'b0, x} - {1'b0, y};
   assign y_sub_x   = {1'b0, y} - {1'b0, x};
   assign iter_next = (iter == CNT_MAX) ? iter : iter + ONE_C;
   assign pre_bad   = !in_p[0] || (in_p == ONE_D) || (in_a == '0) || (in_a >= in_p);

   assign busy     = (state != IDLE);
   assign out_tag  = tag_q;
   assign out_iter = iter;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         u         <= '0;
         v         <= '0;
         x         <= '0;
         y         <= '0;
         p_q       <= '0;
         tag_q     <= '0;
         iter      <= '0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_r     <= '0;
         out_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               in_ready <= 1'b1;
               if (in_valid && in_ready) begin
                  in_ready <= 1'b0;
                  u        <= in_a;
                  v        <= in_p;
                  x        <= ONE_D;
                  y        <= '0;
                  p_q      <= in_p;
                  tag_q    <= in_tag;
                  iter     <= '0;
                  if (pre_bad) begin
                     out_err   <= 1'b1;
                     out_r     <= '0;
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end else begin
                     state <= CHECK;
                  end
               end
            end
            CHECK: begin
               iter <= iter_next;
               if (u == ONE_D) begin
                  out_r     <= x;
                  out_err   <= 1'b0;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else if (v == ONE_D) begin
                  out_r     <= y;
                  out_err   <= 1'b0;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else if (u == '0 || v == '0) begin
                  out_r     <= '0;
                  out_err   <= 1'b1;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else if (!u[0] || !v[0]) begin
                  state <= HALVE;
               end else begin
                  state <= SUB;
               end
            end
            HALVE: begin
               iter <= iter_next;
               if (!u[0]) begin
                  u <= u >> 1;
                  x <= x_half;
               end
               if (!v[0]) begin
                  v <= v >> 1;
                  y <= y_half;
               end
               state <= CHECK;
            end
            SUB: begin
               iter <= iter_next;
               if (!u_sub_v[DATA_WIDTH]) begin
                  u <= u_sub_v[DATA_WIDTH-1:0];
                  x <= x_sub_y[DATA_WIDTH] ? x_sub_y[DATA_WIDTH-1:0] + p_q : x_sub_y[DATA_WIDTH-1:0];
               end else begin
                  v <= v_sub_u[DATA_WIDTH-1:0];
                  y <= y_sub_x[DATA_WIDTH] ? y_sub_x[DATA_WIDTH-1:0] + p_q : y_sub_x[DATA_WIDTH-1:0];
               end
               state <= CHECK;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mod_inverse_engine.sv
// tb/tb_mod_inverse_engine.sv - randomized self-checking bench for mod_inverse_engine
module tb_mod_inverse_engine;

   localparam int DW  = 256;
   localparam int TW  = 8;
   localparam int CW  = 16;
   localparam int LIM = 8 * DW + 20;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_a = '0;
   logic [DW-1:0] in_p = '0;
   logic [TW-1:0] in_tag = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [DW-1:0] out_r;
   logic          out_err;
   logic [TW-1:0] out_tag;
   logic [CW-1:0] out_iter;
   logic          busy;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   mod_inverse_engine #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_p(in_p), .in_tag(in_tag), .out_valid(out_valid),
      .out_ready(out_ready), .out_r(out_r), .out_err(out_err), .out_tag(out_tag),
      .out_iter(out_iter), .busy(busy)
   );

   function automatic logic [DW-1:0] rand_wide();
      logic [DW-1:0] r;
      for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [DW-1:0] gcd(input logic [DW-1:0] a, input logic [DW-1:0] b);
      logic [DW-1:0] t;
      while (b != '0) begin
         t = a % b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   function automatic bit is_inverse(input logic [DW-1:0] a, input logic [DW-1:0] r,
                                     input logic [DW-1:0] p);
      logic [2*DW-1:0] prod;
      prod = {{DW{1'b0}}, a} * {{DW{1'b0}}, r};
      return (r < p) && ((prod % {{DW{1'b0}}, p}) == 1);
   endfunction

   // Caller is positioned just after a negedge; returns at the negedge after acceptance.
   task automatic start_req(input logic [DW-1:0] a, input logic [DW-1:0] p, input logic [TW-1:0] tag);
      int n;
      in_a = a;
      in_p = p;
      in_tag = tag;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < LIM) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (!in_ready) begin
         bad++;
         $display("FAIL accept_timeout in_ready=%0b required=1", in_ready);
      end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_result(output int cycles);
      cycles = 1;
      while (!out_valid && cycles < LIM) begin
         @(negedge clk);
         cycles++;
      end
      total++;
      if (!out_valid) begin
         bad++;
         $display("FAIL result_timeout out_valid=%0b required=1", out_valid);
      end
   endtask

   task automatic check_job(input string name, input logic [DW-1:0] a, input logic [DW-1:0] p,
                            input logic [DW-1:0] exp_r, input bit exp_err,
                            input int exp_iter, input int exp_cycles);
      int cyc;
      start_req(a, p, 8'h11);
      wait_result(cyc);
      total++;
      if (out_r !== exp_r || out_err !== exp_err) begin
         bad++;
         $display("FAIL %s_result r=%0d err=%0b required r=%0d err=%0b", name, out_r, out_err, exp_r, exp_err);
      end
      total++;
      if (out_iter !== CW'(exp_iter) || cyc != exp_cycles) begin
         bad++;
         $display("FAIL %s_timing iter=%0d cycles=%0d required iter=%0d cycles=%0d",
                  name, out_iter, cyc, exp_iter, exp_cycles);
      end
      total++;
      if (out_tag !== 8'h11) begin
         bad++;
         $display("FAIL %s_tag tag=%0h required=11", name, out_tag);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || out_err !== 1'b0 ||
          out_r !== '0 || out_tag !== '0 || out_iter !== '0) begin
         bad++;
         $display("FAIL reset_values in_ready=%0b out_valid=%0b busy=%0b err=%0b r=%0d tag=%0h iter=%0d required all 0",
                  in_ready, out_valid, busy, out_err, out_r, out_tag, out_iter);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_idle_ready in_ready=%0b required=1", in_ready);
      end
   endtask

   task automatic test_known_values();
      check_job("inv_3_7", 256'd3, 256'd7, 256'd5, 1'b0, 7, 8);
      check_job("gcd_6_9", 256'd6, 256'd9, 256'd0, 1'b1, 9, 10);
   endtask

   task automatic test_precheck();
      check_job("even_p", 256'd3, 256'd8, 256'd0, 1'b1, 0, 1);
      check_job("a_zero", 256'd0, 256'd7, 256'd0, 1'b1, 0, 1);
      check_job("a_eq_p", 256'd7, 256'd7, 256'd0, 1'b1, 0, 1);
      check_job("p_one",  256'd0, 256'd1, 256'd0, 1'b1, 0, 1);
   endtask

   task automatic test_backpressure();
      int cyc;
      logic [DW-1:0] r0;
      logic [CW-1:0] it0;
      bit stable;
      out_ready = 1'b0;
      start_req(256'd2, 256'd9, 8'hA5);
      wait_result(cyc);
      total++;
      if (out_r !== 256'd5 || out_err !== 1'b0 || out_tag !== 8'hA5) begin
         bad++;
         $display("FAIL bp_result r=%0d err=%0b tag=%0h required r=5 err=0 tag=a5", out_r, out_err, out_tag);
      end
      r0 = out_r;
      it0 = out_iter;
      in_a = 256'd4;
      in_p = 256'd9;
      in_tag = 8'h3C;
      in_valid = 1'b1;
      stable = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_r !== r0 || out_iter !== it0 ||
             out_tag !== 8'hA5 || out_err !== 1'b0)
            stable = 1'b0;
      end
      total++;
      if (!stable) begin
         bad++;
         $display("FAIL bp_hold valid=%0b in_ready=%0b r=%0d tag=%0h required held valid=1 in_ready=0 r=5 tag=a5",
                  out_valid, in_ready, out_r, out_tag);
      end
      out_ready = 1'b1;
      @(negedge clk);
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL bp_release in_ready=%0b valid=%0b busy=%0b required 1 0 0", in_ready, out_valid, busy);
      end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      wait_result(cyc);
      total++;
      if (out_r !== 256'd7 || out_err !== 1'b0 || out_tag !== 8'h3C) begin
         bad++;
         $display("FAIL bp_pending r=%0d err=%0b tag=%0h required r=7 err=0 tag=3c", out_r, out_err, out_tag);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_job();
      start_req(256'd3, 256'd7, 8'h42);
      @(negedge clk);
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL midrst_busy busy=%0b required=1", busy);
      end
      rst_n = 1'b0;
      #1;
      total++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || out_iter !== '0 || out_tag !== '0) begin
         bad++;
         $display("FAIL midrst_async valid=%0b busy=%0b in_ready=%0b iter=%0d tag=%0h required all 0",
                  out_valid, busy, in_ready, out_iter, out_tag);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check_job("after_rst", 256'd3, 256'd7, 256'd5, 1'b0, 7, 8);
   endtask

   task automatic test_random_back_to_back(input int trials);
      logic [DW-1:0] a, p, g;
      logic [TW-1:0] tag;
      int cyc;
      out_ready = 1'b1;
      for (int t = 0; t < trials; t++) begin
         p = rand_wide();
         p[DW-1] = 1'b0;
         p[0] = 1'b1;
         if (p < 3) p = 256'd3;
         if (t % 4 == 0) begin
            p = p - (p % 3);
            if (!p[0]) p = p + 3;
            a = 3 * (rand_wide() % (p / 3));
            if (a == '0) a = 256'd3;
         end else begin
            a = rand_wide() % p;
            if (a == '0) a = 256'd1;
         end
         tag = TW'($urandom);
         g = gcd(p, a);
         start_req(a, p, tag);
         wait_result(cyc);
         total++;
         if (g != 1) begin
            if (out_err !== 1'b1 || out_r !== '0) begin
               bad++;
               $display("FAIL rand_err trial=%0d err=%0b r=%0h required err=1 r=0", t, out_err, out_r);
            end
         end else if (out_err !== 1'b0 || !is_inverse(a, out_r, p)) begin
            bad++;
            $display("FAIL rand_inv trial=%0d err=%0b r=%0h required a*r mod p == 1", t, out_err, out_r);
         end
         total++;
         if (out_tag !== tag) begin
            bad++;
            $display("FAIL rand_tag trial=%0d tag=%0h required=%0h", t, out_tag, tag);
         end
         @(negedge clk);
         total++;
         if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL rand_ready_after_hs trial=%0d in_ready=%0b required=1", t, in_ready);
         end
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_known_values();
      test_precheck();
      test_backpressure();
      test_reset_mid_job();
      test_random_back_to_back(40);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
